move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer_if.sv | 30 +++
 rtl/move_sequencer.sv | 175 +++++++++++++++++
 tb/tb_move_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// ============================================================================
// Module  : move_sequencer_if
// Purpose : Solver/button inputs and move-display outputs of move_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface move_sequencer_if;
    logic        comp;
    logic [33:0] ord;
    logic [4:0]  len;
    logic        btn;
    logic        auto_en;
    logic [1:0]  move;
    logic [4:0]  step;
    logic        valid;
    logic        done;

    modport master (
        output comp, ord, len, btn, auto_en,
        input  move, step, valid, done
    );

    modport slave (
        input  comp, ord, len, btn, auto_en,
        output move, step, valid, done
    );
endinterface

`default_nettype wire

// File: rtl/move_sequencer.sv
// ============================================================================
// Module  : move_sequencer
// Purpose : Steps through a captured solver move list on button presses or a
//           periodic auto-advance timer, showing one move at a time.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module move_sequencer #(
    parameter int DEB_CYCLES  = 16,
    parameter int AUTO_PERIOD = 50_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    move_sequencer_if.slave   bus
);

    localparam int              c_deb_w    = (DEB_CYCLES  > 2) ? $clog2(DEB_CYCLES)  : 1;
    localparam int              c_tmr_w    = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(AUTO_PERIOD - 1);
    localparam logic [4:0]      c_max_len  = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic [1:0]           sync_q,       sync_d;
    logic                 deb_q,        deb_d;
    logic [c_deb_w-1:0]   deb_cnt_q,    deb_cnt_d;
    logic                 deb_prev_q,   deb_prev_d;
    logic                 comp_dly_q,   comp_dly_d;
    logic [4:0]           idx_q,        idx_d;
    logic [c_tmr_w-1:0]   timer_q,      timer_d;
    logic [33:0]          shadow_ord_q, shadow_ord_d;
    logic [4:0]           shadow_len_q, shadow_len_d;
    logic [1:0]           move_q,       move_d;
    logic [4:0]           step_q,       step_d;
    logic                 valid_q,      valid_d;
    logic                 done_q,       done_d;

    logic                 w_press;
    logic                 w_expire;
    logic                 w_advance;
    logic                 w_comp_rise;
    logic [4:0]           w_len_clamp;

    // Synchronizer and debouncer: level flips only after DEB_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        sync_d     = {sync_q[0], bus.btn};
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_prev_d = deb_q;
        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == c_deb_last) begin
                deb_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + c_deb_w'(1);
            end
        end
    end

    assign w_press     = deb_q & ~deb_prev_q;
    assign w_expire    = bus.auto_en && (timer_q == c_tmr_last);
    assign w_advance   = w_press | w_expire;
    assign w_comp_rise = bus.comp & ~comp_dly_q;
    assign w_len_clamp = (bus.len > c_max_len) ? c_max_len : bus.len;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = '0;
        shadow_ord_d = shadow_ord_q;
        shadow_len_d = shadow_len_q;
        comp_dly_d   = bus.comp;

        // Dropping comp wins over any press or timer expiry in the same cycle.
        if (!bus.comp) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_comp_rise) begin
                        shadow_ord_d = bus.ord;
                        shadow_len_d = w_len_clamp;
                        idx_d        = '0;
                        state_d      = (w_len_clamp == 5'd0) ? DONE : SHOW;
                    end
                end
                SHOW: begin
                    if (w_advance) begin
                        if (idx_q == shadow_len_q - 5'd1) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end else if (bus.auto_en) begin
                        timer_d = timer_q + c_tmr_w'(1);
                    end
                end
                DONE: begin
                    if (w_press && (shadow_len_q != 5'd0)) begin
                        state_d = SHOW;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        // Outputs follow the next state so they land on the same edge.
        move_d  = '0;
        step_d  = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (state_d == SHOW) begin
            move_d  = shadow_ord_d[{idx_d, 1'b0} +: 2];
            step_d  = idx_d + 5'd1;
            valid_d = 1'b1;
        end else if (state_d == DONE) begin
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            deb_q        <= 1'b0;
            deb_cnt_q    <= '0;
            deb_prev_q   <= 1'b0;
            comp_dly_q   <= 1'b0;
            idx_q        <= '0;
            timer_q      <= '0;
            shadow_ord_q <= '0;
            shadow_len_q <= '0;
            move_q       <= '0;
            step_q       <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            deb_prev_q   <= deb_prev_d;
            comp_dly_q   <= comp_dly_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            shadow_ord_q <= shadow_ord_d;
            shadow_len_q <= shadow_len_d;
            move_q       <= move_d;
            step_q       <= step_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.move  = move_q;
    assign bus.step  = step_q;
    assign bus.valid = valid_q;
    assign bus.done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// ============================================================================
// Module  : tb_move_sequencer
// Purpose : Directed vector table plus hand sequences for move_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_move_sequencer;

    localparam int DEB = 4;
    localparam int AP  = 8;

    localparam logic [1:0]  UP = 2'd0, DOWN = 2'd1, RIGHT = 2'd2, LEFT = 2'd3;
    localparam logic [33:0] ORD_A = 34'h0_0000_001C;   // UP, LEFT, DOWN
    localparam logic [33:0] ORD_G = 34'h2_AAAA_AAAA;   // all RIGHT
    localparam logic [33:0] ORD_B = 34'h1_2345_6789;
    localparam logic [33:0] ORD_C = 34'h2_D8E4_1B72;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    move_sequencer_if bus ();

    move_sequencer #(.DEB_CYCLES(DEB), .AUTO_PERIOD(AP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        comp;
        logic [33:0] ord;
        logic [4:0]  len;
        logic        btn;
        logic        auto_en;
        int          ncyc;
        logic [1:0]  e_move;
        logic [4:0]  e_step;
        logic        e_valid;
        logic        e_done;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] em, input logic [4:0] es,
                       input logic ev, input logic ed);
        n_cmp++;
        if ({bus.move, bus.step, bus.valid, bus.done} !== {em, es, ev, ed}) begin
            n_err++;
            $display("FAIL %s: got move=%0d step=%0d valid=%0b done=%0b, want move=%0d step=%0d valid=%0b done=%0b",
                     nm, bus.move, bus.step, bus.valid, bus.done, em, es, ev, ed);
        end
    endtask

    function automatic logic [1:0] mv(input logic [33:0] o, input int i);
        return o[2*i +: 2];
    endfunction

    task automatic capture(input logic [33:0] o, input logic [4:0] l, input logic a);
        bus.comp = 1'b0;
        tick(1);
        bus.comp = 1'b1; bus.ord = o; bus.len = l; bus.auto_en = a;
        tick(1);
    endtask

    task automatic press_release();
        bus.btn = 1'b1; tick(7);
        bus.btn = 1'b0; tick(8);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 34'h0, 5'd0,  1'b0, 1'b0, 2, 2'd0,  5'd0, 1'b0, 1'b0, "idle"};
        vecs[1]  = '{1'b1, ORD_A, 5'd3,  1'b0, 1'b0, 1, UP,    5'd1, 1'b1, 1'b0, "capture"};
        vecs[2]  = '{1'b1, ORD_A, 5'd3,  1'b1, 1'b0, 6, UP,    5'd1, 1'b1, 1'b0, "press1_early"};
        vecs[3]  = '{1'b1, ORD_A, 5'd3,  1'b1, 1'b0, 1, LEFT,  5'd2, 1'b1, 1'b0, "press1"};
        vecs[4]  = '{1'b1, ORD_A, 5'd3,  1'b0, 1'b0, 8, LEFT,  5'd2, 1'b1, 1'b0, "release1"};
        vecs[5]  = '{1'b1, ORD_G, 5'd5,  1'b1, 1'b0, 7, DOWN,  5'd3, 1'b1, 1'b0, "press2_ord_ignored"};
        vecs[6]  = '{1'b1, ORD_G, 5'd5,  1'b0, 1'b0, 8, DOWN,  5'd3, 1'b1, 1'b0, "release2"};
        vecs[7]  = '{1'b1, ORD_G, 5'd5,  1'b1, 1'b0, 7, 2'd0,  5'd0, 1'b0, 1'b1, "press3_done"};
        vecs[8]  = '{1'b1, ORD_G, 5'd5,  1'b0, 1'b0, 8, 2'd0,  5'd0, 1'b0, 1'b1, "release3"};
        vecs[9]  = '{1'b1, ORD_G, 5'd5,  1'b1, 1'b0, 7, UP,    5'd1, 1'b1, 1'b0, "replay"};
        vecs[10] = '{1'b1, ORD_G, 5'd5,  1'b0, 1'b0, 8, UP,    5'd1, 1'b1, 1'b0, "release4"};
        vecs[11] = '{1'b0, ORD_G, 5'd5,  1'b0, 1'b0, 1, 2'd0,  5'd0, 1'b0, 1'b0, "comp_drop"};
        vecs[12] = '{1'b1, ORD_B, 5'd20, 1'b0, 1'b0, 1, DOWN,  5'd1, 1'b1, 1'b0, "recapture"};

        bus.comp = 1'b0; bus.ord = '0; bus.len = '0; bus.btn = 1'b0; bus.auto_en = 1'b0;
        #12;
        chk("reset", 2'd0, 5'd0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.comp = vecs[i].comp; bus.ord = vecs[i].ord; bus.len = vecs[i].len;
            bus.btn = vecs[i].btn; bus.auto_en = vecs[i].auto_en;
            tick(vecs[i].ncyc);
            chk(vecs[i].name, vecs[i].e_move, vecs[i].e_step, vecs[i].e_valid, vecs[i].e_done);
        end

        // Auto advance every AP clocks; len 20 clamps to 17 moves.
        capture(ORD_C, 5'd20, 1'b1);
        chk("auto_start", mv(ORD_C, 0), 5'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            tick(AP - 1);
            chk("auto_hold", mv(ORD_C, k - 1), 5'(k), 1'b1, 1'b0);
            tick(1);
            if (k < 17) chk("auto_step", mv(ORD_C, k), 5'(k + 1), 1'b1, 1'b0);
            else        chk("auto_done", 2'd0, 5'd0, 1'b0, 1'b1);
        end

        // Press pulse lands on the same edge as timer expiry: one advance only.
        capture(ORD_C, 5'd17, 1'b1);
        tick(1);
        bus.btn = 1'b1;
        tick(6);
        chk("coinc_before", mv(ORD_C, 0), 5'd1, 1'b1, 1'b0);
        tick(1);
        chk("coinc_single", mv(ORD_C, 1), 5'd2, 1'b1, 1'b0);
        tick(7);
        chk("coinc_hold", mv(ORD_C, 1), 5'd2, 1'b1, 1'b0);
        tick(1);
        chk("coinc_next", mv(ORD_C, 2), 5'd3, 1'b1, 1'b0);
        bus.btn = 1'b0; bus.auto_en = 1'b0;
        tick(8);

        // Zero-length list goes straight to DONE and a press cannot leave it.
        capture(ORD_C, 5'd0, 1'b0);
        chk("len0_done", 2'd0, 5'd0, 1'b0, 1'b1);
        press_release();
        chk("len0_press", 2'd0, 5'd0, 1'b0, 1'b1);

        // comp falls on the same edge a press acts at step 5.
        capture(ORD_C, 5'd17, 1'b0);
        for (int p = 0; p < 4; p++) press_release();
        chk("step5", mv(ORD_C, 4), 5'd5, 1'b1, 1'b0);
        bus.btn = 1'b1;
        tick(6);
        chk("pre_drop", mv(ORD_C, 4), 5'd5, 1'b1, 1'b0);
        bus.comp = 1'b0;
        tick(1);
        chk("drop_wins", 2'd0, 5'd0, 1'b0, 1'b0);
        bus.btn = 1'b0; bus.comp = 1'b1; bus.ord = ORD_B; bus.len = 5'd3;
        tick(1);
        chk("rerise", mv(ORD_B, 0), 5'd1, 1'b1, 1'b0);
        tick(8);
        chk("no_queued", mv(ORD_B, 0), 5'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle at step 9, released with comp high.
        capture(ORD_C, 5'd17, 1'b1);
        tick(8 * AP);
        chk("step9", mv(ORD_C, 8), 5'd9, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", 2'd0, 5'd0, 1'b0, 1'b0);
        bus.auto_en = 1'b0;
        tick(1);
        chk("rst_held", 2'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_recapture", mv(ORD_C, 0), 5'd1, 1'b1, 1'b0);

        // Bouncing button: toggles every 2 clocks, then held high.
        for (int t = 0; t < 5; t++) begin
            bus.btn = 1'b1; tick(2);
            bus.btn = 1'b0; tick(2);
        end
        chk("bounce_none", mv(ORD_C, 0), 5'd1, 1'b1, 1'b0);
        bus.btn = 1'b1;
        tick(DEB + 2);
        chk("bounce_early", mv(ORD_C, 0), 5'd1, 1'b1, 1'b0);
        tick(1);
        chk("bounce_step", mv(ORD_C, 1), 5'd2, 1'b1, 1'b0);
        tick(9);
        chk("bounce_once", mv(ORD_C, 1), 5'd2, 1'b1, 1'b0);
        bus.btn = 1'b0;
        tick(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
